// File: rtl/raster_pkg.sv
// Shared types for the triangle scanline path: vertex records, the sequencer
// state encoding and the stable compare-swap used by the y sorter.
package raster_pkg;

  localparam int FRAC_BITS = 5;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

  typedef vertex_t [2:0] tri_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SORT,
    S_SETUP,
    S_EDGE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RELEASE,
    S_NEXT,
    S_FINISH
  } sched_state_t;

  // Swap only on strictly greater y so equal-y vertices keep their input order.
  function automatic tri_t cswap(input tri_t t, input logic [1:0] i, input logic [1:0] j);
    tri_t r;
    r = t;
    if (t[i].y > t[j].y) begin
      r[i] = t[j];
      r[j] = t[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/vertex_sort3.sv
// Three-stage registered stable sort of a triangle's vertices by y.
// Output index 0 is the top vertex (min y), index 2 the bottom.
module vertex_sort3
  import raster_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  tri_t in_tri,
  output logic out_valid,
  output tri_t out_tri
);

  localparam int STAGES = 3;

  logic [STAGES:1] vld_pipe;
  tri_t s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Data stages only advance with their valid bit so the result holds after the pulse.
  always_ff @(posedge clk) begin
    if (in_valid)    s1 <= cswap(in_tri, 2'd0, 2'd1);
    if (vld_pipe[1]) s2 <= cswap(s1, 2'd1, 2'd2);
    if (vld_pipe[2]) s3 <= cswap(s2, 2'd0, 2'd1);
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_tri   = s3;

endmodule

// File: rtl/triangle_scanline_ctrl.sv
// Scanline sequencer: sorts one triangle by y, then walks its scanlines and
// hands each pair of active edges to draw_line with a start/done handshake.
module triangle_scanline_ctrl #(
  parameter int FRAC_BITS    = raster_pkg::FRAC_BITS,
  parameter int SCREEN_H     = 480,
  parameter int LINE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [15:0] v0x, v0y, v0z,
  input  logic [15:0] v1x, v1y, v1z,
  input  logic [15:0] v2x, v2y, v2z,
  output logic        line_start,
  input  logic        line_done,
  output logic [15:0] y_coord,
  output logic [15:0] pax, pay, paz,
  output logic [15:0] pbx, pby, pbz,
  output logic [15:0] pcx, pcy, pcz,
  output logic [15:0] pdx, pdy, pdz,
  output logic        tri_done,
  output logic        timeout_err
);
  import raster_pkg::*;

  localparam int              WD_W    = $clog2(LINE_TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(LINE_TIMEOUT - 1);
  localparam logic [15:0]     Y_LIMIT = 16'(SCREEN_H);

  sched_state_t    state, state_nx;
  tri_t            in_tri, sorted;
  logic            sort_vld, accept, done_ok, wd_exp;
  vertex_t         pa, pb, pc, pd;
  logic [15:0]     y, y_mid, y_bot;
  logic [WD_W-1:0] wd;

  assign in_tri = {vertex_t'{v2x, v2y, v2z}, vertex_t'{v1x, v1y, v1z}, vertex_t'{v0x, v0y, v0z}};

  vertex_sort3 u_sort (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept),
    .in_tri   (in_tri),
    .out_valid(sort_vld),
    .out_tri  (sorted)
  );

  assign tri_ready = (state == S_IDLE);
  assign tri_done  = (state == S_FINISH);
  assign accept    = tri_valid & tri_ready;
  // A done seen in the first start cycle may be stale from the previous line.
  assign done_ok   = line_done && (wd != '0);
  assign wd_exp    = (wd == WD_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (accept) state_nx = S_SORT;
      S_SORT:      if (sort_vld) state_nx = S_SETUP;
      S_SETUP:     state_nx = S_EDGE;
      S_EDGE:      state_nx = (y >= Y_LIMIT) ? S_FINISH : S_ISSUE;
      S_ISSUE:     state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (done_ok) state_nx = S_RELEASE;
                   else if (wd_exp) state_nx = S_FINISH;
      S_RELEASE:   if (!line_done) state_nx = S_NEXT;
      S_NEXT:      state_nx = (y == y_bot) ? S_FINISH : S_EDGE;
      S_FINISH:    state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y           <= '0;
      y_mid       <= '0;
      y_bot       <= '0;
      pa          <= '0;
      pb          <= '0;
      pc          <= '0;
      pd          <= '0;
      wd          <= '0;
      line_start  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) timeout_err <= 1'b0;
        S_SETUP: begin
          y     <= sorted[0].y >> FRAC_BITS;
          y_mid <= sorted[1].y >> FRAC_BITS;
          y_bot <= sorted[2].y >> FRAC_BITS;
        end
        S_EDGE: if (y < Y_LIMIT) begin
          // Upper half walks T->M, lower half M->B; the long edge is always T->B.
          if (y < y_mid) begin
            pa <= sorted[0];
            pb <= sorted[1];
          end else begin
            pa <= sorted[1];
            pb <= sorted[2];
          end
          pc <= sorted[0];
          pd <= sorted[2];
        end
        S_ISSUE: begin
          line_start <= 1'b1;
          wd         <= '0;
        end
        S_WAIT_DONE: begin
          wd <= wd + 1'b1;
          if (done_ok) begin
            line_start <= 1'b0;
          end else if (wd_exp) begin
            line_start  <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        S_NEXT: if (y != y_bot) y <= y + 16'd1;
        default: ;
      endcase
    end
  end

  assign y_coord = y;
  assign {pax, pay, paz} = pa;
  assign {pbx, pby, pbz} = pb;
  assign {pcx, pcy, pcz} = pc;
  assign {pdx, pdy, pdz} = pd;

endmodule
